// File: rtl/usr_seq_ctrl_if.sv
// Command handshake bundle between host and usr_seq_ctrl.
// master: host drives valid/op/data/count/fill; slave: controller drives ready.
interface usr_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_fill;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    output cmd_count, cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    input  cmd_count, cmd_fill,
    output cmd_ready
  );
endinterface

// File: rtl/usr_seq_ctrl.sv
// Sequencer driving a universal shift register: load/shr/shl/rotr by count.
// Ports: clk, reset (sync, high), cmd (slave handshake), usr_q in;
// usr_s/usr_d/usr_sr/usr_sl to the USR, busy, done pulse out.
// Build option USR_SEQ_PRELOAD_EN: shift ops load cmd_data first.
module usr_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  usr_seq_ctrl_if.slave    cmd,
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       usr_s,
  output logic [WIDTH-1:0] usr_d,
  output logic             usr_sr,
  output logic             usr_sl,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_SHR  = 2'b01;
  localparam logic [1:0] S_SHL  = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic             fill_q;
  logic [CNT_W-1:0] cnt;
  logic             sr_fill;
  logic             rot;

  logic [1:0]       sel_op;
  logic             sel_fill;
  logic [1:0]       sh_s;
  logic             sh_sl;
  logic             sh_sr;
  logic             sh_rot;
  logic             load_first;
  logic             unused_q;

  // Shift-cycle outputs come from the live command when entering
  // SHIFT from IDLE, otherwise from the captured copy.
  assign sel_op   = (state == IDLE) ? cmd.cmd_op : op_q;
  assign sel_fill = (state == IDLE) ? cmd.cmd_fill : fill_q;
  assign sh_s     = (sel_op == OP_SHL) ? S_SHL : S_SHR;
  assign sh_sl    = (sel_op == OP_SHL) & sel_fill;
  assign sh_sr    = (sel_op == OP_SHR) & sel_fill;
  assign sh_rot   = (sel_op == OP_ROTR);

`ifdef USR_SEQ_PRELOAD_EN
  assign load_first = 1'b1;
`else
  assign load_first = (cmd.cmd_op == OP_LOAD);
`endif

  assign cmd.cmd_ready = (state == IDLE) && !reset;

  // Rotate feeds the bit leaving Q[0] straight back into SR.
  assign usr_sr   = rot ? usr_q[0] : sr_fill;
  assign unused_q = ^usr_q[WIDTH-1:1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= OP_LOAD;
      fill_q  <= 1'b0;
      cnt     <= '0;
      usr_s   <= S_HOLD;
      usr_d   <= '0;
      usr_sl  <= 1'b0;
      sr_fill <= 1'b0;
      rot     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      usr_s   <= S_HOLD;
      usr_d   <= '0;
      usr_sl  <= 1'b0;
      sr_fill <= 1'b0;
      rot     <= 1'b0;
      busy    <= 1'b1;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (cmd.cmd_valid) begin
            op_q   <= cmd.cmd_op;
            fill_q <= cmd.cmd_fill;
            cnt    <= cmd.cmd_count;
            busy   <= 1'b1;
            if (load_first) begin
              state <= LOAD;
              usr_s <= S_LOAD;
              usr_d <= cmd.cmd_data;
            end else if (cmd.cmd_count != '0) begin
              state   <= SHIFT;
              usr_s   <= sh_s;
              usr_sl  <= sh_sl;
              sr_fill <= sh_sr;
              rot     <= sh_rot;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          // Only a preloaded shift op continues into SHIFT.
          if (op_q != OP_LOAD && cnt != '0) begin
            state   <= SHIFT;
            usr_s   <= sh_s;
            usr_sl  <= sh_sl;
            sr_fill <= sh_sr;
            rot     <= sh_rot;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt     <= cnt - CNT_W'(1);
            usr_s   <= sh_s;
            usr_sl  <= sh_sl;
            sr_fill <= sh_sr;
            rot     <= sh_rot;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Scoreboard bench for usr_seq_ctrl driving a behavioural 4-bit USR.
// Stimulus pushes expected results; a negedge monitor pops on done.
module tb_usr_seq_ctrl;
  localparam int W  = 4;
  localparam int CW = 3;

  localparam logic [1:0] LD = 2'b00;
  localparam logic [1:0] SR = 2'b01;
  localparam logic [1:0] SL = 2'b10;
  localparam logic [1:0] RR = 2'b11;

`ifdef USR_SEQ_PRELOAD_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] q = '0;
  logic [1:0]   usr_s;
  logic [W-1:0] usr_d;
  logic         usr_sr;
  logic         usr_sl;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  usr_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) cmd ();

  usr_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .cmd    (cmd),
    .usr_q  (q),
    .usr_s  (usr_s),
    .usr_d  (usr_d),
    .usr_sr (usr_sr),
    .usr_sl (usr_sl),
    .busy   (busy),
    .done   (done)
  );

  always @(posedge clk) begin
    case (usr_s)
      2'b01:   q <= {usr_sr, q[W-1:1]};
      2'b10:   q <= {q[W-2:0], usr_sl};
      2'b11:   q <= usr_d;
      default: q <= q;
    endcase
  end

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] data;
    logic         fill;
    logic [W-1:0] q;
    int           lat;
    int           shifts;
    int           loads;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   acc_cnt  = 0;
  int   done_cnt = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // lat = negedge index of the done cycle, counting from the accept edge.
  task automatic push(logic [1:0] op, logic [W-1:0] data,
                      int count, logic fill, logic [W-1:0] qx);
    exp_t e;
    e.op     = op;
    e.data   = data;
    e.fill   = fill;
    e.q      = qx;
    e.lat    = (op == LD) ? 2 : count + 1 + PRE;
    e.shifts = (op == LD) ? 0 : count;
    e.loads  = (op == LD || PRE == 1) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic send(logic [1:0] op, logic [W-1:0] data,
                      int count, logic fill);
    int g = 0;
    while (!cmd.cmd_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 50) chk("ready_timeout", 0, 1);
    cmd.cmd_op    = op;
    cmd.cmd_data  = data;
    cmd.cmd_count = CW'(count);
    cmd.cmd_fill  = fill;
    cmd.cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_data  = ~data;
    cmd.cmd_fill  = ~fill;
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin
      @(posedge clk); #1;
      g++;
    end while ((busy || sb.size() != 0) && g < 60);
    if (g >= 60) chk("done_timeout", 0, 1);
  endtask

  task automatic run(logic [1:0] op, logic [W-1:0] data,
                     int count, logic fill, logic [W-1:0] qx);
    push(op, data, count, fill, qx);
    send(op, data, count, fill);
    wait_idle();
  endtask

  bit   inf = 0;
  int   lat, shifts, loads;
  bit   bad;
  exp_t cur;

  always @(negedge clk) begin
    if (reset) begin
      inf = 0;
    end else begin
      if (inf) begin
        lat++;
        if (sb.size() > 0) begin
          cur = sb[0];
          if (usr_s != 2'b11 && usr_d !== '0) bad = 1;
          if (done && usr_s !== 2'b00) bad = 1;
          case (usr_s)
            2'b11: begin
              loads++;
              if (usr_d !== cur.data) bad = 1;
            end
            2'b01, 2'b10: begin
              shifts++;
              case (cur.op)
                SR: if (!(usr_s == 2'b01 && usr_sr === cur.fill
                          && usr_sl === 1'b0)) bad = 1;
                SL: if (!(usr_s == 2'b10 && usr_sl === cur.fill
                          && usr_sr === 1'b0)) bad = 1;
                RR: if (!(usr_s == 2'b01 && usr_sr === q[0]
                          && usr_sl === 1'b0)) bad = 1;
                default: bad = 1;
              endcase
            end
            default: ;
          endcase
        end
      end
      if (done) begin
        done_cnt++;
        if (!inf || sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          cur = sb.pop_front();
          chk("q", 32'(q), 32'(cur.q));
          chk("latency", lat, cur.lat);
          chk("shift_cycles", shifts, cur.shifts);
          chk("load_cycles", loads, cur.loads);
          chk("pin_values", 32'(bad), 0);
        end
        inf = 0;
      end
      if (cmd.cmd_valid && cmd.cmd_ready) begin
        inf    = 1;
        lat    = 0;
        shifts = 0;
        loads  = 0;
        bad    = 0;
        acc_cnt++;
      end
    end
  end

  initial begin
    int target;
    int g;
    int dsave;
    bit rb;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = LD;
    cmd.cmd_data  = '0;
    cmd.cmd_count = '0;
    cmd.cmd_fill  = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cmd.cmd_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_s", 32'(usr_s), 0);
    chk("rst_d", 32'(usr_d), 0);
    chk("rst_serial", 32'({usr_sr, usr_sl}), 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(cmd.cmd_ready), 1);

`ifdef USR_SEQ_PRELOAD_EN
    run(LD, 4'b0011, 0, 1'b0, 4'b0011);
    run(SL, 4'b0001, 2, 1'b1, 4'b0111);
    run(SR, 4'b1000, 0, 1'b0, 4'b1000);
    run(RR, 4'b1010, 1, 1'b0, 4'b0101);
`else
    run(LD, 4'b1010, 0, 1'b0, 4'b1010);
    chk("ready_after_load", 32'(cmd.cmd_ready), 1);

    run(LD, 4'b0000, 0, 1'b0, 4'b0000);
    run(SR, 4'b0110, 4, 1'b1, 4'b1111);

    push(SL, 4'b0000, 4, 1'b0, 4'b0000);
    push(SL, 4'b0000, 4, 1'b0, 4'b0000);
    cmd.cmd_op    = SL;
    cmd.cmd_data  = 4'b0000;
    cmd.cmd_count = CW'(4);
    cmd.cmd_fill  = 1'b0;
    cmd.cmd_valid = 1'b1;
    target = acc_cnt + 2;
    rb = 0;
    g  = 0;
    do begin
      @(posedge clk); #1;
      if (busy && cmd.cmd_ready) rb = 1;
      g++;
    end while (acc_cnt < target && g < 60);
    cmd.cmd_valid = 1'b0;
    if (g >= 60) chk("hold_timeout", 0, 1);
    chk("ready_while_busy", 32'(rb), 0);
    wait_idle();

    run(LD, 4'b1010, 0, 1'b0, 4'b1010);
    run(RR, 4'b0000, 1, 1'b0, 4'b0101);
    run(RR, 4'b0000, 4, 1'b0, 4'b0101);
    run(SR, 4'b1111, 0, 1'b1, 4'b0101);

    run(LD, 4'b0000, 0, 1'b0, 4'b0000);
    dsave = done_cnt;
    send(SR, 4'b0000, 4, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_s", 32'(usr_s), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_ready", 32'(cmd.cmd_ready), 0);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", 32'(cmd.cmd_ready), 1);
    chk("abort_no_done", done_cnt, dsave);
    run(LD, 4'b0011, 0, 1'b0, 4'b0011);
`endif

    repeat (2) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
